// File: rtl/instr_loader.sv
// Instruction-memory program loader: assembles an MSB-first byte stream into
// 32-bit words, writes them to consecutive addresses and holds the CPU meanwhile.
module instr_loader #(
  parameter int unsigned DEPTH  = 56,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              reloj,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] n_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] target;
  logic              load;
  logic              accept;
  logic              last_word;

  assign last_word = (ADDR_W'(word_count + 1'b1) == target);

  // Next-state decode; abort wins over a same-cycle byte.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        if (abort) begin
          state_next = IDLE;
        end else if (byte_valid) begin
          accept = 1'b1;
          if (byte_idx == 2'd3) state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = last_word ? DONE : RECV;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and status flags registered from the next state.
  always_ff @(posedge reloj) begin
    if (reset) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      target     <= DEPTH_A;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      byte_ready <= (state_next == RECV);
      wr_en      <= (state_next == WRITE);
      cpu_hold   <= (state_next == RECV) || (state_next == WRITE);
      done       <= (state_next == DONE);
      if (load) begin
        target     <= ((n_words == '0) || (n_words > DEPTH_A)) ? DEPTH_A : n_words;
        wr_addr    <= '0;
        byte_idx   <= 2'd0;
        word_count <= '0;
      end
      if (accept) begin
        wr_data  <= {wr_data[DATA_W-9:0], byte_in};
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == WRITE) begin
        word_count <= ADDR_W'(word_count + 1'b1);
        if (!last_word) wr_addr <= ADDR_W'(wr_addr + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued as words are
// driven and checked against every wr_en pulse.
module tb_instr_loader;
  localparam int unsigned DEPTH = 56;

  logic        reloj = 1'b0;
  logic        reset, start, abort, byte_valid;
  logic [5:0]  n_words;
  logic [7:0]  byte_in;
  logic        byte_ready, wr_en, cpu_hold, done;
  logic [5:0]  wr_addr, word_count;
  logic [31:0] wr_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_cnt = 0;
  int last_wr_cyc = -100;
  int gap_q[$];
  logic [5:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  instr_loader dut (
    .reloj(reloj), .reset(reset), .start(start), .abort(abort),
    .n_words(n_words), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done),
    .word_count(word_count)
  );

  always #5 reloj = ~reloj;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled mid-cycle.
  always @(negedge reloj) begin
    logic [5:0]  ea;
    logic [31:0] ed;
    cyc++;
    if (wr_en === 1'b1) begin
      chk("wr_ready_low", 64'(byte_ready), 64'd0);
      chk("wr_addr_range", 64'(wr_addr < 6'(DEPTH)), 64'd1);
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_wr", 64'(wr_addr), 64'hFFFF);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(ea));
        chk("wr_data", 64'(wr_data), 64'(ed));
      end
      gap_q.push_back(cyc - last_wr_cyc);
      last_wr_cyc = cyc;
      wr_cnt++;
    end
  end

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  // Idle `gap` cycles, then offer a byte until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      r = byte_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input logic [5:0] addr);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic start_session(input logic [5:0] n);
    byte_valid = 1'b0;
    n_words    = n;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("start_hold", 64'(cpu_hold), 64'd1);
    chk("start_ready", 64'(byte_ready), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    logic ph;
    bit ok;
    ok = 1'b0;
    ph = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      ph = cpu_hold;
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    if (ok) begin
      chk({tag, "_hold_before"}, 64'(ph), 64'd1);
      chk({tag, "_hold_after"}, 64'(cpu_hold), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] w;
    int wc0;
    time t0;

    reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    n_words = '0; byte_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_ready", 64'(byte_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    chk("rst_data", 64'(wr_data), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(word_count), 64'd0);

    // Two-word load, continuous stream.
    gap_q.delete();
    start_session(6'd2);
    send_word(32'h2008_0005, 0, 6'd0);
    send_word(32'hAC01_0004, 0, 6'd1);
    wait_done("two");
    chk("two_count", 64'(word_count), 64'd2);
    chk("two_gap", 64'(gap_q.size() == 2 ? gap_q[1] : -1), 64'd5);
    byte_valid = 1'b0;

    // Full-depth load with n_words = 0.
    wc0 = wr_cnt;
    start_session(6'd0);
    t0 = $time;
    for (int i = 0; i < 56; i++) begin
      w = $urandom;
      send_word(w, 0, 6'(i));
    end
    wait_done("full");
    chk("full_dur", 64'((($time - t0) / 10) >= 280), 64'd1);
    chk("full_writes", 64'(wr_cnt - wc0), 64'd56);
    chk("full_addr", 64'(wr_addr), 64'd55);
    chk("full_count", 64'(word_count), 64'd56);
    byte_valid = 1'b1;
    repeat (10) tick();
    chk("full_no_extra", 64'(wr_cnt - wc0), 64'd56);
    chk("full_ready_low", 64'(byte_ready), 64'd0);
    chk("full_done_held", 64'(done), 64'd1);
    byte_valid = 1'b0;

    // Gapped stream.
    start_session(6'd2);
    send_word(32'h2008_0005, 3, 6'd0);
    send_word(32'hAC01_0004, 3, 6'd1);
    wait_done("gap");
    chk("gap_count", 64'(word_count), 64'd2);
    byte_valid = 1'b0;

    // Abort after one word plus two bytes, with a byte offered on the abort edge.
    start_session(6'd4);
    send_word(32'h1234_5678, 0, 6'd0);
    send_byte(8'h9A, 0);
    send_byte(8'hBC, 0);
    wc0 = wr_cnt;
    byte_in = 8'h77;
    abort   = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", 64'(byte_ready), 64'd0);
    chk("abort_hold", 64'(cpu_hold), 64'd0);
    chk("abort_count", 64'(word_count), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    repeat (8) tick();
    chk("abort_no_wr", 64'(wr_cnt - wc0), 64'd0);
    byte_valid = 1'b0;
    start_session(6'd1);
    chk("abort_restart_addr", 64'(wr_addr), 64'd0);
    send_word(32'hCAFE_F00D, 0, 6'd0);
    wait_done("restart");
    byte_valid = 1'b0;

    // Reset after three bytes of word 0.
    start_session(6'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    wc0 = wr_cnt;
    byte_in = 8'h44;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_ready", 64'(byte_ready), 64'd0);
    chk("mrst_wr_en", 64'(wr_en), 64'd0);
    chk("mrst_addr", 64'(wr_addr), 64'd0);
    chk("mrst_data", 64'(wr_data), 64'd0);
    chk("mrst_hold", 64'(cpu_hold), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_count", 64'(word_count), 64'd0);
    repeat (6) tick();
    chk("mrst_no_wr", 64'(wr_cnt - wc0), 64'd0);
    byte_valid = 1'b0;

    // Start ignored mid-session, then start from DONE.
    start_session(6'd3);
    send_word(32'h0102_0304, 0, 6'd0);
    exp_addr_q.push_back(6'd1);
    exp_data_q.push_back(32'hA1B2_C3D4);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    byte_valid = 1'b0;
    n_words = 6'd5;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_count", 64'(word_count), 64'd1);
    chk("ign_addr", 64'(wr_addr), 64'd1);
    chk("ign_ready", 64'(byte_ready), 64'd1);
    send_byte(8'hC3, 0);
    send_byte(8'hD4, 0);
    send_word(32'hDEAD_BEEF, 0, 6'd2);
    wait_done("ign");
    chk("ign_final_count", 64'(word_count), 64'd3);
    chk("ign_final_addr", 64'(wr_addr), 64'd2);
    start_session(6'd1);
    chk("redo_done", 64'(done), 64'd0);
    chk("redo_count", 64'(word_count), 64'd0);
    chk("redo_addr", 64'(wr_addr), 64'd0);
    send_word(32'h0BAD_F00D, 0, 6'd0);
    wait_done("redo");
    chk("redo_final_count", 64'(word_count), 64'd1);
    byte_valid = 1'b0;

    repeat (3) tick();
    chk("sb_leftover", 64'(exp_addr_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader for the instruction memory: the write-side counterpart of the 6-bit-address, 32-bit-word instruction ROM read by the datapath. It accepts a byte stream (e.g. from a UART receiver) over a valid/ready handshake, assembles bytes MSB-first into 32-bit instructions, and writes them to consecutive addresses starting at 0. While a load is in progress it holds the processor in reset.

## Interface
- `DEPTH`, 56: number of instruction-memory entries.
- `ADDR_W`, 6: write-address width.
- `DATA_W`, 32: instruction width; fixed at 4 bytes.
- `reloj`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load session; sampled only in IDLE or DONE.
- `abort`  in  1  cancel the session; sampled only in RECV.
- `n_words`  in  6  words to load; 0 or >DEPTH means DEPTH; latched on `start`.
- `byte_in`  in  8  incoming byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `wr_en`  out  1  one-cycle write strobe to the instruction memory.
- `wr_addr`  out  6  write address.
- `wr_data`  out  32  assembled instruction.
- `cpu_hold`  out  1  holds the processor in reset while loading.
- `done`  out  1  session completed; level output.
- `word_count`  out  6  words written in the current or last session.

## Operation
- States: IDLE, RECV, WRITE, DONE. Reset puts the FSM in IDLE.
- IDLE to RECV on `start`:
  - latch target = (`n_words`==0 or `n_words`>DEPTH) ? DEPTH : `n_words`;
  - clear `wr_addr`, the byte index, `word_count` and `done`.
- RECV:
  - `byte_ready`=1 and `cpu_hold`=1.
  - A byte is accepted on each edge where `byte_valid` && `byte_ready`: shift register <= {sr[23:0], `byte_in`} and the byte index increments mod 4. The first byte received becomes bits [31:24].
  - On the 4th accepted byte, go to WRITE.
  - `abort` (priority over a same-cycle byte) goes to IDLE: the partial word is discarded, already-written words remain, `word_count` holds.
- WRITE (exactly one cycle):
  - `wr_en`=1, `byte_ready`=0, `cpu_hold`=1; `wr_data` is the assembled word and `wr_addr` the current address.
  - Next edge: `word_count` increments. If `word_count`+1 == target, go to DONE with `wr_addr` held. Otherwise `wr_addr` increments and the FSM returns to RECV.
  - `start` and `abort` are ignored here.
- DONE:
  - `done`=1, `cpu_hold`=0, `byte_ready`=0.
  - `start` begins a new session exactly as from IDLE, clearing `done`.
- `start` in RECV or WRITE is ignored. `abort` outside RECV is ignored.
- `wr_addr` never exceeds DEPTH-1; no write is ever issued to address ≥ DEPTH.
- Bytes presented while `byte_ready`=0 are not consumed; the upstream must hold them.

## Timing
- Reset values: `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=0, `done`=0, `word_count`=0. Reset mid-session discards the partial word, and no `wr_en` is issued.
- All outputs are registered or decoded from state only. There is no combinational path from `byte_valid` to `byte_ready`.
- `cpu_hold` rises the cycle after `start` is sampled and falls the cycle after the last WRITE (same edge `done` rises). After an abort, it falls the cycle after `abort` is sampled.
- `wr_en` asserts the cycle after the 4th byte handshake, for exactly one cycle.
- Minimum throughput: 5 cycles per word (4 accept cycles + 1 WRITE). A full 56-word load takes ≥ 280 cycles after `start`.

## Test plan
- **Two-word load:** `n_words`=2, `byte_valid` held high with bytes 20 08 00 05 AC 01 00 04.
  - Required: `wr_en` pulses with addr 0 / data 0x20080005, then addr 1 / data 0xAC010004, 5 cycles apart.
  - Then `done`=1, `word_count`=2, and `cpu_hold` falls together with `done` rising.
- **Full-depth load:** `n_words`=0 with 224 bytes.
  - Required: 56 writes at addr 0..55; `done` follows the addr-55 write; `wr_addr` stays 55 and there is no 57th write.
- **Gapped stream:** `byte_valid` low for 3 cycles between each byte.
  - Required: identical words and addresses.
  - `byte_ready`=0 during WRITE, and a byte offered in that cycle is consumed only after the return to RECV.
- **Abort:** `n_words`=4; `abort` after 1 full word plus 2 bytes.
  - Required: no second `wr_en`, FSM in IDLE, `word_count`=1, `cpu_hold`=0.
  - A following `start` rewrites from addr 0.
- **Reset mid-word:** `reset` high for 1 cycle after 3 bytes of word 0.
  - Required: all outputs at reset values the next cycle; no write occurs.
- **Start handling:** `start` pulsed during RECV is ignored (count and address unchanged).
  - `start` in DONE clears `done`, `word_count` and `wr_addr`, and raises `cpu_hold` the next cycle.
